// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared response codes, size and state encodings for the load/store bus unit
package lsu_pkg;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } lsu_err_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Right-aligned byte-lane mask covering one access of the given size.
    function automatic logic [7:0] size_lanes(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_align_bits(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd0;
            SZ_H:    return 3'd1;
            SZ_W:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_unit_if.sv
// rtl/lsu_bus_unit_if.sv - handshaked bus between the load/store unit and the bus bridge
interface lsu_bus_unit_if #(
    parameter int XLEN = 32
) ();
    localparam int NB = XLEN / 8;

    logic            Bus_req;
    logic [31:0]     Bus_addr;
    logic            Bus_we;
    logic [NB-1:0]   Bus_be;
    logic [XLEN-1:0] Bus_wdata;
    logic            Bus_ack;
    logic [XLEN-1:0] Bus_rdata;

    modport master (
        output Bus_req, Bus_addr, Bus_we, Bus_be, Bus_wdata,
        input  Bus_ack, Bus_rdata
    );

    modport slave (
        input  Bus_req, Bus_addr, Bus_we, Bus_be, Bus_wdata,
        output Bus_ack, Bus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane shifting, byte enables, alignment check and load extension
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OB   = $clog2(NB)
) (
    input  logic [1:0]      size,
    input  logic [OB-1:0]   offset,
    input  logic            uns,
    input  logic [XLEN-1:0] data,
    output logic [NB-1:0]   be,
    output logic [XLEN-1:0] data_st,
    output logic [XLEN-1:0] data_ld,
    output logic            misalign
);

    logic [NB-1:0]   lane_mask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep_mask;
    logic            sign_bit;

    always_comb begin
        lane_mask = NB'(size_lanes(size));
        be        = lane_mask << offset;
        data_st   = data << {offset, 3'b000};
        shifted   = data >> {offset, 3'b000};
        misalign  = ((size == SZ_D) && (XLEN == 32)) ||
                    ((offset & OB'(size_align_bits(size))) != '0);
    end

    // Extension keeps the low access bits and fills the rest with the sign copy or zeros.
    always_comb begin
        keep_mask = '1;
        sign_bit  = 1'b0;
        case (size)
            SZ_B: begin
                keep_mask = XLEN'(8'hFF);
                sign_bit  = shifted[7];
            end
            SZ_H: begin
                keep_mask = XLEN'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            SZ_W: begin
                keep_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
        data_ld = (shifted & keep_mask) | ((sign_bit & ~uns) ? ~keep_mask : '0);
    end

endmodule

// File: rtl/lsu_bus_unit.sv
// rtl/lsu_bus_unit.sv - multi-cycle load/store bus master with byte enables, extension and wait timeout
module lsu_bus_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic [1:0]      resp_err,
    output logic            lsu_busy,
    lsu_bus_unit_if.master  bus
);

    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_e      state_q, state_d;
    logic [31:0]     addr_q;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [OB-1:0]   off_q;
    logic [NB-1:0]   be_q;
    logic [XLEN-1:0] wdata_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rdata_q;
    lsu_err_e        err_q;

    logic            in_idle;
    logic            cnt_done;
    logic [1:0]      al_size;
    logic [OB-1:0]   al_offset;
    logic            al_uns;
    logic [XLEN-1:0] al_data;
    logic [NB-1:0]   al_be;
    logic [XLEN-1:0] al_data_st;
    logic [XLEN-1:0] al_data_ld;
    logic            al_misalign;

    assign in_idle  = (state_q == IDLE);
    assign cnt_done = (cnt_q == CW'(TIMEOUT));

    // One aligner serves both directions: request fields while idle, captured fields afterwards.
    assign al_size   = in_idle ? req_size          : size_q;
    assign al_offset = in_idle ? req_addr[OB-1:0]  : off_q;
    assign al_uns    = in_idle ? req_unsigned      : uns_q;
    assign al_data   = in_idle ? req_wdata         : bus.Bus_rdata;

    lsu_align #(.XLEN(XLEN)) u_align (
        .size     (al_size),
        .offset   (al_offset),
        .uns      (al_uns),
        .data     (al_data),
        .be       (al_be),
        .data_st  (al_data_st),
        .data_ld  (al_data_ld),
        .misalign (al_misalign)
    );

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = al_misalign ? RESP : BUS;
            BUS:     if (bus.Bus_ack || cnt_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= {req_addr[31:OB], {OB{1'b0}}};
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        off_q   <= req_addr[OB-1:0];
                        be_q    <= al_be;
                        wdata_q <= al_data_st;
                        cnt_q   <= '0;
                        rdata_q <= '0;
                        err_q   <= al_misalign ? ERR_MISALIGN : ERR_NONE;
                    end
                end
                BUS: begin
                    // An ack in the final wait cycle still completes the access normally.
                    if (bus.Bus_ack) begin
                        rdata_q <= we_q ? '0 : al_data_ld;
                        err_q   <= ERR_NONE;
                    end else if (cnt_done) begin
                        err_q   <= ERR_TIMEOUT;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = in_idle;
    assign lsu_busy      = ~in_idle;
    assign resp_valid    = (state_q == RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;

    assign bus.Bus_req   = (state_q == BUS);
    assign bus.Bus_addr  = addr_q;
    assign bus.Bus_we    = we_q;
    assign bus.Bus_be    = be_q;
    assign bus.Bus_wdata = wdata_q;

endmodule
